// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures bytes on the end-of-reception
// strobe and presents them first-word-fall-through, with fill-level and sticky overrun flags.
module uart_rx_fifo #(
  parameter int DataWidth       = 8,
  parameter int Depth           = 16,
  parameter int AlmostFullLevel = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [DataWidth-1:0]       din_i,
  output logic [DataWidth-1:0]       dout_o,
  output logic                       dout_valid_o,
  input  logic                       dout_ready_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 r_overflow;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overrun;

  // Status is decoded only from the registered count, so no input reaches an output combinationally.
  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CntW'(Depth));
  assign w_pop     = w_valid && dout_ready_i;
  assign w_push    = wr_en_i && (!w_full || w_pop);
  assign w_overrun = wr_en_i && w_full && !w_pop;

  assign dout_o        = r_mem[r_rd_ptr];
  assign dout_valid_o  = w_valid;
  assign count_o       = r_count;
  assign empty_o       = !w_valid;
  assign full_o        = w_full;
  assign almost_full_o = (r_count >= CntW'(AlmostFullLevel));
  assign overflow_o    = r_overflow;

  // NOTE: storage has no reset; pointers and count define which entries are live, and a
  // resettable array would block RAM inference.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);

      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);

      // A new overrun outranks a clear requested in the same cycle.
      if (w_overrun)      r_overflow <= 1'b1;
      else if (clr_ovf_i) r_overflow <= 1'b0;
    end
  end

endmodule
